instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_if #(
   parameter int unsigned WIDTH = 32
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [31:0]      imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding imem reads into a small FIFO feeding decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_CHECK_EN (adds fetch_fault).
module instr_fetch #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] next_pc,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   instr_fetch_if.master    imem,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [31:0]      instr,
   output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic             fetch_fault
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tag_q, tag_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [WIDTH-1:0] addr_q [DEPTH];
   logic [WIDTH-1:0] addr_d [DEPTH];

   logic             req_c;
   logic [WIDTH-1:0] next_pc_c;
   logic             push_c;
   logic             pop_c;
   logic             outstanding_c;
   logic             room_c;
   logic             fetch_ok_c;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q, fault_d;
`endif

   // State and buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '{default: '0};
         addr_q   <= '{default: '0};
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_q  <= fault_d;
`endif
      end
   end

   // Next-state, request and buffer-update logic
   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      data_d    = data_q;
      addr_d    = addr_q;
      req_c     = 1'b0;
      next_pc_c = pc;
      push_c    = 1'b0;
      pop_c     = 1'b0;

      outstanding_c = (state_q == WAIT) || (state_q == DROP);
      room_c        = (count_q + CNT_W'(outstanding_c)) < CNT_W'(DEPTH);
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d    = fault_q;
      fetch_ok_c = !fault_q && (pc[1:0] == 2'b00);
`else
      fetch_ok_c = 1'b1;
`endif

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect) begin
               // A grant seen alongside a redirect is treated as a read in flight.
               if (imem.imem_gnt) state_d = DROP;
            end else if (room_c && fetch_ok_c) begin
               req_c = 1'b1;
               if (imem.imem_gnt) begin
                  tag_d     = pc;
                  state_d   = WAIT;
                  next_pc_c = pc + WIDTH'(4);
               end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (!redirect && (pc[1:0] != 2'b00)) fault_d = 1'b1;
`endif
         end
         WAIT: begin
            if (imem.imem_rvalid) begin
               state_d = REQ;
               push_c  = !redirect;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem.imem_rvalid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      pop_c = (count_q != '0) && instr_ready && !redirect;

      if (redirect) begin
         next_pc_c = redirect_pc;
         rd_ptr_d  = wr_ptr_q;
         count_d   = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_d   = 1'b0;
`endif
      end else begin
         if (push_c) begin
            data_d[wr_ptr_q] = imem.imem_rdata;
            addr_d[wr_ptr_q] = tag_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end

      // Reset holds the PC steady and keeps the bus quiet even before the first edge.
      if (rst) begin
         req_c     = 1'b0;
         next_pc_c = pc;
      end
   end

   assign next_pc        = next_pc_c;
   assign imem.imem_req  = req_c;
   assign imem.imem_addr = req_c ? pc : '0;
   assign instr_valid    = (count_q != '0);
   assign instr          = data_q[rd_ptr_q];
   assign instr_pc       = addr_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
   assign fetch_fault    = fault_q;
`endif

endmodule
